// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bit-scan unit.
package bitscan_pkg;

  typedef enum logic [1:0] {
    MODE_CLZ    = 2'b00,
    MODE_CTZ    = 2'b01,
    MODE_POPCNT = 2'b10,
    MODE_CLO    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  // Width needed to hold any count from 0 up to and including width.
  function automatic int unsigned count_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bitscan_chunk.sv
// Combinational analysis of one CHUNK-bit slice: nonzero flag, leading and
// trailing zero counts (CHUNK when the slice is zero), and population count.
module bitscan_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0]       bits,
  output logic                   nonzero,
  output logic [$clog2(CHUNK):0] lz,
  output logic [$clog2(CHUNK):0] tz,
  output logic [$clog2(CHUNK):0] pop
);

  localparam int unsigned CW = $clog2(CHUNK) + 1;

  // Any set bit in the slice.
  always_comb begin
    nonzero = |bits;
  end

  // Leading zeros: walk from the MSB, stop at the first one.
  always_comb begin
    logic [CHUNK-1:0] t;
    logic             found;
    t     = bits;
    found = 1'b0;
    lz    = CW'(CHUNK);
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (!found && t[CHUNK-1]) begin
        lz    = CW'(i);
        found = 1'b1;
      end
      t = t << 1;
    end
  end

  // Trailing zeros: walk from the LSB, stop at the first one.
  always_comb begin
    logic [CHUNK-1:0] t;
    logic             found;
    t     = bits;
    found = 1'b0;
    tz    = CW'(CHUNK);
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (!found && t[0]) begin
        tz    = CW'(i);
        found = 1'b1;
      end
      t = t >> 1;
    end
  end

  // Population count of the slice.
  always_comb begin
    logic [CHUNK-1:0] t;
    t   = bits;
    pop = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      pop = pop + CW'(t[0]);
      t   = t >> 1;
    end
  end

endmodule

// File: rtl/bitscan_unit.sv
// Multi-cycle CLZ/CTZ/POPCNT/CLO engine scanning CHUNK bits per cycle behind
// valid/ready handshakes; result is zero-extended to RESULT_W bits.
module bitscan_unit
  import bitscan_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHUNK    = 4,
  parameter int unsigned RESULT_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [WIDTH-1:0]    in_a,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result
);

  localparam int unsigned CNT_W  = count_w(WIDTH);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CCW    = $clog2(CHUNK) + 1;

  state_t               state, state_n;
  mode_t                mode_q;
  logic [WIDTH-1:0]     opnd;
  logic [KW-1:0]        k;
  logic [CNT_W-1:0]     acc;
  logic [RESULT_W-1:0]  result_q;

  logic [WIDTH-1:0]     up_sh, dn_sh;
  logic [CHUNK-1:0]     chunk_bits;
  logic                 nonzero;
  logic [CCW-1:0]       lz, tz, pop;
  logic [CNT_W-1:0]     base, scan_val;
  logic                 last, scan_end;

  // Select chunk k: MSB-first for CLZ (CLO is stored inverted as CLZ),
  // LSB-first for CTZ and POPCNT.
  always_comb begin
    up_sh = opnd << (32'(k) * CHUNK);
    dn_sh = opnd >> (32'(k) * CHUNK);
    if (mode_q == MODE_CTZ || mode_q == MODE_POPCNT) begin
      chunk_bits = dn_sh[CHUNK-1:0];
    end else begin
      chunk_bits = up_sh[WIDTH-1 -: CHUNK];
    end
  end

  bitscan_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits    (chunk_bits),
    .nonzero (nonzero),
    .lz      (lz),
    .tz      (tz),
    .pop     (pop)
  );

  // Candidate result for this cycle; a zero final chunk yields base+CHUNK = WIDTH.
  always_comb begin
    base = CNT_W'(k) * CNT_W'(CHUNK);
    last = (k == KW'(NCHUNK - 1));
    case (mode_q)
      MODE_CTZ:    scan_val = base + CNT_W'(tz);
      MODE_POPCNT: scan_val = acc + CNT_W'(pop);
      default:     scan_val = base + CNT_W'(lz);
    endcase
    scan_end = last || (nonzero && mode_q != MODE_POPCNT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_SCAN;
      end
      S_SCAN: begin
        if (scan_end) state_n = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand latch, chunk index, accumulator and result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q   <= MODE_CLZ;
      opnd     <= '0;
      k        <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (mode_t'(in_mode) == MODE_CLO) begin
              opnd   <= ~in_a;
              mode_q <= MODE_CLZ;
            end else begin
              opnd   <= in_a;
              mode_q <= mode_t'(in_mode);
            end
            k   <= '0;
            acc <= '0;
          end
        end
        S_SCAN: begin
          if (scan_end) begin
            result_q <= RESULT_W'(scan_val);
          end else begin
            k   <= k + KW'(1);
            acc <= scan_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = result_q;

endmodule
